// File: rtl/network_top_fx_pkg.sv
// Fixed-point types and the shared round/saturate helper for the LSTM gate path.
package network_top_fx_pkg;

  localparam int DATA_W    = 12;
  localparam int FRAC_BITS = 8;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int ACC_W     = 32;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_e;

  // Saturation flag packed above the requantized value.
  typedef struct packed {
    logic  sat;
    data_t data;
  } rs_t;

  localparam acc_t DATA_MAX = acc_t'((1 << (DATA_W - 1)) - 1);
  localparam acc_t DATA_MIN = acc_t'(-(1 << (DATA_W - 1)));
  localparam acc_t RND_HALF = acc_t'(1 << (FRAC_BITS - 1));

  // Round half-up, drop FRAC_BITS fractional bits, clip to data_t range.
  function automatic rs_t fx_round_sat(input acc_t s);
    acc_t r;
    rs_t  o;
    r = (s + RND_HALF) >>> FRAC_BITS;
    if (r > DATA_MAX) begin
      o.sat  = 1'b1;
      o.data = DATA_MAX[DATA_W-1:0];
    end else if (r < DATA_MIN) begin
      o.sat  = 1'b1;
      o.data = DATA_MIN[DATA_W-1:0];
    end else begin
      o.sat  = 1'b0;
      o.data = r[DATA_W-1:0];
    end
    return o;
  endfunction

endpackage

// File: rtl/network_top_round_sat.sv
// Combinational requantizer: wide Q.2F sum -> rounded, clipped Q.F result.
module network_top_round_sat
  import network_top_fx_pkg::*;
(
  input  logic signed [ACC_W-1:0]  sum,
  output logic signed [DATA_W-1:0] data,
  output logic                     sat
);

  rs_t rs;

  // Pure function of the sum; no state.
  always_comb begin
    rs   = fx_round_sat(sum);
    data = rs.data;
    sat  = rs.sat;
  end

endmodule

// File: rtl/network_top_dot_acc.sv
// Gate dot-product accumulator: bias + sum of products, one requantized result per vector.
module network_top_dot_acc
  import network_top_fx_pkg::*;
#(
  parameter int MAX_LEN = 256
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] prod_data,
  input  logic                     prod_first,
  input  logic                     prod_last,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  acc_state_e       state, state_nx;
  acc_t             acc, base, sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  data_t            rs_data;
  logic             rs_sat;

  // Input stalls only while a held result is not being drained.
  assign prod_ready = !out_valid || out_ready;
  assign accept     = prod_valid && prod_ready;

  // Next running sum and accumulator state; first restarts from the bias.
  always_comb begin
    state_nx = state;
    base     = (state == ACC_RUN) ? acc : '0;
    if (prod_first) sum = (acc_t'(bias) <<< FRAC_BITS) + acc_t'(prod_data);
    else            sum = base + acc_t'(prod_data);
    if (accept) state_nx = prod_last ? ACC_IDLE : ACC_RUN;
  end

  network_top_round_sat u_rs (
    .sum  (sum),
    .data (rs_data),
    .sat  (rs_sat)
  );

  // Accumulator state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= ACC_IDLE;
    else        state <= state_nx;
  end

  // Partial sum and beat count; both clear when a vector closes.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= prod_last ? '0 : sum;
      if (prod_last)                    cnt <= '0;
      else if (prod_first)              cnt <= CNT_W'(1);
      else if (cnt != CNT_W'(MAX_LEN))  cnt <= cnt + 1'b1;
    end
  end

  // Single output slot; a new result overwrites a draining one without a bubble.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (accept && prod_last) begin
      out_valid <= 1'b1;
      out_data  <= rs_data;
      out_sat   <= rs_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_network_top_dot_acc.sv
// Bench for the gate dot-product accumulator.
module tb_network_top_dot_acc;

  logic                ap_clk = 1'b0;
  logic                ap_rst = 1'b1;
  logic signed [23:0]  prod_data = '0;
  logic                prod_first = 1'b0, prod_last = 1'b0, prod_valid = 1'b0;
  logic                prod_ready;
  logic signed [11:0]  bias = '0;
  logic signed [11:0]  out_data;
  logic                out_sat, out_valid;
  logic                out_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  network_top_dot_acc dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_data(prod_data), .prod_first(prod_first), .prod_last(prod_last),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .bias(bias),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference requantizer: floor((S + 128) / 256), clipped to 12-bit signed.
  function automatic void ref_q(input longint s, output logic signed [11:0] d, output logic sat);
    longint t, q;
    t = s + 128;
    q = t / 256;
    if ((t % 256) != 0 && t < 0) q = q - 1;
    if (q > 2047)       begin d = 12'h7FF; sat = 1'b1; end
    else if (q < -2048) begin d = 12'h800; sat = 1'b1; end
    else                begin d = q[11:0]; sat = 1'b0; end
  endfunction

  // Present one beat and return #1 after the edge that accepted it; prod_valid stays high.
  task automatic drive_beat(input int d, input bit f, input bit l, input int b);
    prod_data  = 24'(d);
    prod_first = f;
    prod_last  = l;
    bias       = 12'(b);
    prod_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (prod_ready) begin
        @(posedge ap_clk); #1;
        return;
      end
    end
    total++; bad++;
    $display("FAIL accept_timeout: beat not accepted, prod_ready=%0b required 1", prod_ready);
  endtask

  task automatic test_reset;
    ap_rst = 1'b1; out_ready = 1'b1;
    @(negedge ap_clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    total++; if (out_data !== 12'sd0) begin bad++; $display("FAIL rst_data: got %0d want 0", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL rst_sat: got %0b want 0", out_sat); end
    total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", prod_ready); end
    @(posedge ap_clk); #2 ap_rst = 1'b0;
    // Mid-vector async reset, then a clean single-beat vector.
    drive_beat(65536, 1, 0, 0);
    drive_beat(65536, 0, 0, 0);
    prod_valid = 1'b0;
    #2 ap_rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %0b want 0", out_valid); end
    @(posedge ap_clk); #2 ap_rst = 1'b0;
    drive_beat(65536, 1, 1, 0);
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_valid !== 1'b1 || out_data !== 12'sd256 || out_sat !== 1'b0) begin
      bad++; $display("FAIL rst_after: got v=%0b d=%0d s=%0b want v=1 d=256 s=0", out_valid, out_data, out_sat);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_protocol;
    // Partial discarded by reset; a beat without first ignores bias.
    drive_beat(65536, 1, 0, 0);
    prod_valid = 1'b0;
    #2 ap_rst = 1'b1;
    @(posedge ap_clk); #2 ap_rst = 1'b0;
    drive_beat(65536, 0, 1, 512);
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_data !== 12'sd256 || out_valid !== 1'b1) begin
      bad++; $display("FAIL nofirst: got v=%0b d=%0d want v=1 d=256", out_valid, out_data);
    end
    @(posedge ap_clk); #1;
    // First arriving mid-vector restarts the sum.
    drive_beat(131072, 1, 0, 0);
    drive_beat(0, 1, 1, 256);
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_data !== 12'sd256) begin bad++; $display("FAIL restart: got %0d want 256", out_data); end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_three_beat;
    drive_beat(65536, 1, 0, 0);
    drive_beat(65536, 0, 0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL three_early: got %0b want 0", out_valid); end
    drive_beat(65536, 0, 1, 0);
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_valid !== 1'b1 || out_data !== 12'sd768 || out_sat !== 1'b0) begin
      bad++; $display("FAIL three_res: got v=%0b d=%0d s=%0b want v=1 d=768 s=0", out_valid, out_data, out_sat);
    end
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL three_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_round;
    int p[3]; int b[3]; logic signed [11:0] e[3];
    p = '{128, -128, -32768}; b = '{256, 0, 0}; e = '{12'sd257, 12'sd0, -12'sd128};
    for (int i = 0; i < 3; i++) begin
      drive_beat(p[i], 1, 1, b[i]);
      prod_valid = 1'b0;
      @(negedge ap_clk);
      total++; if (out_data !== e[i] || out_sat !== 1'b0) begin
        bad++; $display("FAIL round%0d: got d=%0d s=%0b want d=%0d s=0", i, out_data, out_sat, e[i]);
      end
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_sat;
    for (int i = 0; i < 8; i++) drive_beat(65536, i == 0, i == 7, 0);
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_data !== 12'sd2047 || out_sat !== 1'b1) begin
      bad++; $display("FAIL sat_pos: got d=%0d s=%0b want d=2047 s=1", out_data, out_sat);
    end
    @(posedge ap_clk); #1;
    for (int i = 0; i < 9; i++) drive_beat(-65536, i == 0, i == 8, 0);
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_data !== 12'h800 || out_sat !== 1'b1) begin
      bad++; $display("FAIL sat_neg: got d=%0d s=%0b want d=-2048 s=1", out_data, out_sat);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive_beat(65536, 1, 1, 0);
    prod_data = 24'sd131072; prod_first = 1'b1; prod_last = 1'b1; bias = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      total++; if (prod_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'sd256) begin
        bad++; $display("FAIL bp_hold%0d: got r=%0b v=%0b d=%0d want r=0 v=1 d=256", i, prod_ready, out_valid, out_data);
      end
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    total++; if (prod_ready !== 1'b1 || out_data !== 12'sd256) begin
      bad++; $display("FAIL bp_release: got r=%0b d=%0d want r=1 d=256", prod_ready, out_data);
    end
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_valid !== 1'b1 || out_data !== 12'sd512) begin
      bad++; $display("FAIL bp_second: got v=%0b d=%0d want v=1 d=512", out_valid, out_data);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_back_to_back;
    int p[3]; logic signed [11:0] e[3];
    p = '{65536, 131072, -65536}; e = '{12'sd256, 12'sd512, -12'sd256};
    for (int i = 0; i < 3; i++) begin
      prod_data = 24'(p[i]); prod_first = 1'b1; prod_last = 1'b1; bias = '0; prod_valid = 1'b1;
      @(negedge ap_clk);
      total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %0b want 1", i, prod_ready); end
      if (i > 0) begin
        total++; if (out_valid !== 1'b1 || out_data !== e[i-1]) begin
          bad++; $display("FAIL b2b_res%0d: got v=%0b d=%0d want v=1 d=%0d", i - 1, out_valid, out_data, e[i-1]);
        end
      end
      @(posedge ap_clk); #1;
    end
    prod_valid = 1'b0;
    @(negedge ap_clk);
    total++; if (out_valid !== 1'b1 || out_data !== e[2]) begin
      bad++; $display("FAIL b2b_res2: got v=%0b d=%0d want v=1 d=%0d", out_valid, out_data, e[2]);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_random;
    int n, b, p;
    longint s;
    logic signed [11:0] ed;
    logic es;
    for (int v = 0; v < 30; v++) begin
      n = $urandom_range(1, 10);
      b = int'($urandom_range(0, 4095));
      if (b >= 2048) b -= 4096;
      s = longint'(b) * 256;
      for (int i = 0; i < n; i++) begin
        p = int'($urandom_range(0, 24'hFFFFFF));
        if (p >= (1 << 23)) p -= (1 << 24);
        s += p;
        drive_beat(p, i == 0, i == n - 1, b);
      end
      prod_valid = 1'b0;
      ref_q(s, ed, es);
      @(negedge ap_clk);
      total++; if (out_valid !== 1'b1 || out_data !== ed || out_sat !== es) begin
        bad++; $display("FAIL rand%0d: got v=%0b d=%0d s=%0b want v=1 d=%0d s=%0b", v, out_valid, out_data, out_sat, ed, es);
      end
      @(posedge ap_clk); #1;
      repeat ($urandom_range(0, 2)) @(posedge ap_clk);
      #1;
    end
  endtask

  initial begin
    test_reset;
    test_protocol;
    test_three_beat;
    test_round;
    test_sat;
    test_backpressure;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
